// File: rtl/red_eyes_loader.sv
// Unpacks an MSB-first byte stream into one-pixel-per-cycle writes to a 1-bit layer memory,
// filling linear addresses 0..PIXEL_LIMIT-1. IN_LAST is checked but never changes the length.
module red_eyes_loader #(
   parameter int unsigned X_LIMIT = 240,
   parameter int unsigned Y_LIMIT = 240,
   localparam int unsigned PIXEL_LIMIT = X_LIMIT * Y_LIMIT,
   localparam int unsigned ADDR_W = $clog2(X_LIMIT) + $clog2(Y_LIMIT),
   localparam int unsigned BYTE_LIMIT = (PIXEL_LIMIT + 7) / 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [7:0]        IN_DATA,
   input  logic              IN_VALID,
   input  logic              IN_LAST,
   output logic              IN_READY,
   output logic [ADDR_W-1:0] WRITE_ROM_ADDRESS,
   output logic              WRITE_ROM_DATA,
   output logic              WRITE_ROM,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERROR
);

   localparam int unsigned BYTE_W = $clog2(BYTE_LIMIT + 1);

   typedef enum logic [1:0] {StIdle, StWaitByte, StShift, StFinish} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pix_q, pix_d;
   logic [BYTE_W-1:0]   byte_q, byte_d;
   logic [3:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                last_q, last_d;
   logic                ready_q, ready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                data_q, data_d;
   logic                wr_q, wr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic pix_end, byte_end, emit, emit_bit;

   assign pix_end  = (pix_q == ADDR_W'(PIXEL_LIMIT - 1));
   assign byte_end = (byte_q == BYTE_W'(BYTE_LIMIT - 1));

   always_comb begin
      state_d  = state_q;
      pix_d    = pix_q;
      byte_d   = byte_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      last_d   = last_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = 1'b0;
      err_d    = err_q;
      emit     = 1'b0;
      emit_bit = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d = StWaitByte;
               pix_d   = '0;
               byte_d  = '0;
               last_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         StWaitByte: begin
            // The handshake cycle already emits bit 7, giving 8 strobes plus one ready cycle.
            if (IN_VALID && ready_q) begin
               if (IN_LAST != byte_end) begin
                  err_d = 1'b1;
               end
               byte_d   = byte_q + BYTE_W'(1);
               shift_d  = {IN_DATA[6:0], 1'b0};
               bit_d    = 4'd1;
               emit     = 1'b1;
               emit_bit = IN_DATA[7];
               state_d  = StShift;
            end
         end
         StShift: begin
            if (last_q) begin
               state_d = StFinish;
            end else if (bit_q == 4'd8) begin
               state_d = StWaitByte;
            end else begin
               shift_d  = {shift_q[6:0], 1'b0};
               bit_d    = bit_q + 4'd1;
               emit     = 1'b1;
               emit_bit = shift_q[7];
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Counter saturates on the final pixel so the port never sees PIXEL_LIMIT.
      if (emit) begin
         wr_d   = 1'b1;
         addr_d = pix_q;
         data_d = emit_bit;
         last_d = pix_end;
         if (!pix_end) begin
            pix_d = pix_q + ADDR_W'(1);
         end
      end

      ready_d = (state_d == StWaitByte);
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StFinish);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         pix_q   <= '0;
         byte_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         ready_q <= ready_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign IN_READY          = ready_q;
   assign WRITE_ROM_ADDRESS = addr_q;
   assign WRITE_ROM_DATA    = data_q;
   assign WRITE_ROM         = wr_q;
   assign BUSY              = busy_q;
   assign DONE              = done_q;
   assign ERROR             = err_q;

endmodule

// File: doc/red_eyes_loader.md
# red_eyes_loader

Layer-memory writer for 1-bit animation layers. Accepts a packed bitstream of bytes (8 pixels per byte, MSB first) over a valid/ready stream and drives the layer write port (`WRITE_ROM_ADDRESS` / `WRITE_ROM_DATA` / `WRITE_ROM`) with one pixel per cycle, filling linear addresses 0..PIXEL_LIMIT-1. It sits between the frame-source logic (UART/SPI byte receiver) and the 1-bit layer memory, so layer bitmaps can be replaced at run time without re-synthesis.

## Interface
- `X_LIMIT`, 240, layer width in pixels
- `Y_LIMIT`, 240, layer height in pixels
- derived: `PIXEL_LIMIT` = X_LIMIT*Y_LIMIT; `ADDR_W` = $clog2(X_LIMIT)+$clog2(Y_LIMIT); `BYTE_LIMIT` = ceil(PIXEL_LIMIT/8)

- `CLK` in 1 — single clock for the block
- `RESET` in 1 — synchronous, active-high
- `START` in 1 — begin a load; sampled in IDLE only
- `IN_DATA` in 8 — packed pixels, bit 7 = lowest address
- `IN_VALID` in 1 — IN_DATA valid
- `IN_LAST` in 1 — marks the final byte of the image, qualified by IN_VALID
- `IN_READY` out 1 — byte accepted when IN_VALID && IN_READY
- `WRITE_ROM_ADDRESS` out ADDR_W — linear pixel address
- `WRITE_ROM_DATA` out 1 — pixel value
- `WRITE_ROM` out 1 — write strobe
- `BUSY` out 1 — load in progress
- `DONE` out 1 — one-cycle pulse when the last pixel has been written
- `ERROR` out 1 — sticky; IN_LAST position mismatch; cleared on START or RESET

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, FINISH.
- IDLE: IN_READY=0, BUSY=0. START=1 -> WAIT_BYTE; pixel counter=0, byte counter=0, ERROR cleared.
- WAIT_BYTE: IN_READY=1. On handshake: latch IN_DATA into the shift register, bit counter=0, go to SHIFT. IN_LAST check: IN_LAST=1 on byte index != BYTE_LIMIT-1, or IN_LAST=0 on byte index BYTE_LIMIT-1 -> ERROR=1 (load continues by count; IN_LAST never shortens or extends the load).
- SHIFT: each cycle WRITE_ROM=1, WRITE_ROM_DATA=shift[7], WRITE_ROM_ADDRESS=pixel counter; shift left, pixel counter+1, bit counter+1.
  - pixel counter reaches PIXEL_LIMIT -> FINISH (remaining bits of the final byte are dropped, no strobe).
  - bit counter completes 8 writes -> WAIT_BYTE.
- FINISH: DONE=1 for one cycle, -> IDLE.
- START outside IDLE is ignored. IN_VALID outside WAIT_BYTE is not consumed (IN_READY=0).
- Address arithmetic: pixel counter is ADDR_W bits wide and never exceeds PIXEL_LIMIT-1 when driven onto the port; no wrap-around occurs.
- RESET mid-load: immediate return to IDLE; all outputs to reset values; memory keeps the partially written contents; the in-flight byte is discarded.

## Timing
- All outputs registered. Reset values: IN_READY=0, WRITE_ROM=0, WRITE_ROM_DATA=0, WRITE_ROM_ADDRESS=0, BUSY=0, DONE=0, ERROR=0.
- START sampled at edge N -> IN_READY=1 and BUSY=1 from cycle N+1.
- Byte handshake at edge T -> WRITE_ROM=1 on cycles T+1..T+8 (bit 7..bit 0). IN_READY=0 on those cycles and back to 1 at T+9. Throughput: 1 byte per 9 cycles.
- Last pixel strobe at cycle L -> DONE=1 at cycle L+1 with BUSY still 1. BUSY=0 from L+2.
- WRITE_ROM_ADDRESS and WRITE_ROM_DATA hold their last values when WRITE_ROM=0.
- ERROR is set on the cycle after the offending handshake.

## Test plan
- X=4, Y=4 (16 px, ADDR_W=4), START, then bytes 0xA5 and 0x3C with IN_LAST on the second -> writes at addr 0..15 = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. DONE pulses once, 1 cycle after the addr-15 strobe. ERROR=0.
- X=3, Y=3 (9 px, ADDR_W=4), bytes 0xFF, 0x80 (IN_LAST) -> 9 strobes at addr 0..8, all data=1. No strobe for bits 6..0 of byte 2. DONE follows.
- IN_VALID held low for 20 cycles between bytes -> no strobes during the gap, IN_READY stays 1, BUSY stays 1. Load then completes normally.
- X=4, Y=4, IN_LAST on byte 0 -> ERROR=1 the next cycle. Load still writes all 16 px after byte 1 and DONE pulses. Next START clears ERROR.
- RESET asserted mid-SHIFT after 3 strobes of byte 1 -> next cycle all outputs at reset values, state IDLE. A new START restarts from addr 0.
- START pulsed while BUSY -> ignored, addresses continue sequentially. START in IDLE without IN_VALID -> BUSY=1, no strobes.
